mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 18 +
 rtl/mem_timeout_ctr.sv | 30 +++
 rtl/mem_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory pipeline stage and its wait counter.
package mem_stage_pkg;

    localparam int DATA_W      = 32;
    localparam int REG_W       = 5;
    localparam int CNT_W       = 4;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    function automatic logic is_word_aligned(input logic [DATA_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Bus wait counter: cleared when an access is issued, counts unacknowledged WAIT cycles.
module mem_timeout_ctr
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expiry is seen on the TIMEOUT-th WAIT cycle, i.e. while the count still reads TIMEOUT-1.
    assign o_expired = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory accesses, stalls upstream while waiting,
// and loads the MEM/WB register on completion, misalignment or bus timeout.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_in_valid,
    input  logic              i_flush,
    input  logic              i_mem_read_in,
    input  logic              i_mem_write_in,
    input  logic              i_mem_to_reg_in,
    input  logic              i_reg_write_in,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_store_data,
    input  logic [REG_W-1:0]  i_write_reg,
    output logic              o_stall,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [DATA_W-1:0] o_dmem_addr,
    output logic [DATA_W-1:0] o_dmem_wdata,
    input  logic [DATA_W-1:0] i_dmem_rdata,
    input  logic              i_dmem_ack,
    output logic              o_wb_valid,
    output logic              o_reg_write_out,
    output logic              o_mem_to_reg_out,
    output logic [DATA_W-1:0] o_read_data,
    output logic [DATA_W-1:0] o_alu_out,
    output logic [REG_W-1:0]  o_write_reg_out,
    output logic              o_misalign_err,
    output logic              o_bus_err
);

    state_t              r_state;
    logic [DATA_W-1:0]   r_dmem_addr;
    logic [DATA_W-1:0]   r_dmem_wdata;
    logic                r_dmem_we;
    logic                r_cap_reg_write;
    logic                r_cap_mem_to_reg;
    logic [REG_W-1:0]    r_cap_write_reg;
    logic                r_wb_valid;
    logic                r_reg_write_out;
    logic                r_mem_to_reg_out;
    logic [DATA_W-1:0]   r_read_data;
    logic [DATA_W-1:0]   r_alu_out;
    logic [REG_W-1:0]    r_write_reg_out;
    logic                r_misalign_err;
    logic                r_bus_err;

    logic w_memop;
    logic w_aligned;
    logic w_in_wait;
    logic w_issue;
    logic w_expired;

    assign w_memop   = i_in_valid & (i_mem_read_in | i_mem_write_in);
    assign w_aligned = is_word_aligned(i_alu_result);
    assign w_in_wait = (r_state == S_WAIT);
    assign w_issue   = (r_state == S_IDLE) & w_memop & w_aligned & ~i_flush;

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_issue),
        .i_enable  (w_in_wait & ~i_dmem_ack),
        .o_expired (w_expired)
    );

    // Gated by rst_n so the stall drops the instant reset asserts, even with a memop still presented.
    assign o_stall    = rst_n & (w_issue | (w_in_wait & ~i_dmem_ack));
    assign o_dmem_req = w_in_wait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_dmem_addr      <= '0;
            r_dmem_wdata     <= '0;
            r_dmem_we        <= 1'b0;
            r_cap_reg_write  <= 1'b0;
            r_cap_mem_to_reg <= 1'b0;
            r_cap_write_reg  <= '0;
            r_wb_valid       <= 1'b0;
            r_reg_write_out  <= 1'b0;
            r_mem_to_reg_out <= 1'b0;
            r_read_data      <= '0;
            r_alu_out        <= '0;
            r_write_reg_out  <= '0;
            r_misalign_err   <= 1'b0;
            r_bus_err        <= 1'b0;
        end else begin
            r_wb_valid     <= 1'b0;
            r_misalign_err <= 1'b0;
            r_bus_err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_memop && !i_flush && !w_aligned) begin
                        r_wb_valid       <= 1'b1;
                        r_reg_write_out  <= 1'b0;
                        r_mem_to_reg_out <= i_mem_to_reg_in;
                        r_read_data      <= '0;
                        r_alu_out        <= i_alu_result;
                        r_write_reg_out  <= i_write_reg;
                        r_misalign_err   <= 1'b1;
                    end else if (w_issue) begin
                        // Read+write together behaves as a store that never writes the register file.
                        r_dmem_addr      <= i_alu_result;
                        r_dmem_wdata     <= i_store_data;
                        r_dmem_we        <= i_mem_write_in;
                        r_cap_reg_write  <= i_reg_write_in & ~(i_mem_read_in & i_mem_write_in);
                        r_cap_mem_to_reg <= i_mem_to_reg_in;
                        r_cap_write_reg  <= i_write_reg;
                        r_state          <= S_WAIT;
                    end else begin
                        r_wb_valid       <= i_in_valid & ~i_flush;
                        r_reg_write_out  <= i_reg_write_in;
                        r_mem_to_reg_out <= i_mem_to_reg_in;
                        r_read_data      <= '0;
                        r_alu_out        <= i_alu_result;
                        r_write_reg_out  <= i_write_reg;
                    end
                end
                S_WAIT: begin
                    if (i_dmem_ack) begin
                        r_wb_valid       <= 1'b1;
                        r_reg_write_out  <= r_cap_reg_write;
                        r_mem_to_reg_out <= r_cap_mem_to_reg;
                        r_read_data      <= r_dmem_we ? '0 : i_dmem_rdata;
                        r_alu_out        <= r_dmem_addr;
                        r_write_reg_out  <= r_cap_write_reg;
                        r_state          <= S_IDLE;
                    end else if (w_expired) begin
                        r_wb_valid       <= 1'b1;
                        r_reg_write_out  <= 1'b0;
                        r_mem_to_reg_out <= r_cap_mem_to_reg;
                        r_read_data      <= '0;
                        r_alu_out        <= r_dmem_addr;
                        r_write_reg_out  <= r_cap_write_reg;
                        r_bus_err        <= 1'b1;
                        r_state          <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_dmem_we        = r_dmem_we;
    assign o_dmem_addr      = r_dmem_addr;
    assign o_dmem_wdata     = r_dmem_wdata;
    assign o_wb_valid       = r_wb_valid;
    assign o_reg_write_out  = r_reg_write_out;
    assign o_mem_to_reg_out = r_mem_to_reg_out;
    assign o_read_data      = r_read_data;
    assign o_alu_out        = r_alu_out;
    assign o_write_reg_out  = r_write_reg_out;
    assign o_misalign_err   = r_misalign_err;
    assign o_bus_err        = r_bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// against a transaction-level model of the stage and a behavioural memory.
module tb_mem_stage;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_in_valid = 0, i_flush = 0, i_mem_read_in = 0, i_mem_write_in = 0;
    logic        i_mem_to_reg_in = 0, i_reg_write_in = 0;
    logic [31:0] i_alu_result = '0, i_store_data = '0, i_dmem_rdata = '0;
    logic [4:0]  i_write_reg = '0;
    logic        i_dmem_ack = 0;
    logic        o_stall, o_dmem_req, o_dmem_we, o_wb_valid, o_reg_write_out;
    logic        o_mem_to_reg_out, o_misalign_err, o_bus_err;
    logic [31:0] o_dmem_addr, o_dmem_wdata, o_read_data, o_alu_out;
    logic [4:0]  o_write_reg_out;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .i_in_valid(i_in_valid), .i_flush(i_flush),
        .i_mem_read_in(i_mem_read_in), .i_mem_write_in(i_mem_write_in),
        .i_mem_to_reg_in(i_mem_to_reg_in), .i_reg_write_in(i_reg_write_in),
        .i_alu_result(i_alu_result), .i_store_data(i_store_data), .i_write_reg(i_write_reg),
        .o_stall(o_stall), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_rdata(i_dmem_rdata), .i_dmem_ack(i_dmem_ack),
        .o_wb_valid(o_wb_valid), .o_reg_write_out(o_reg_write_out),
        .o_mem_to_reg_out(o_mem_to_reg_out), .o_read_data(o_read_data),
        .o_alu_out(o_alu_out), .o_write_reg_out(o_write_reg_out),
        .o_misalign_err(o_misalign_err), .o_bus_err(o_bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: one outstanding access record plus the expected MEM/WB contents.
    logic        m_busy = 0;
    int          m_age = 0;
    int          p_lat = 0;
    logic [31:0] p_addr, p_wdata;
    logic        p_we, p_rw, p_m2r;
    logic [4:0]  p_wr;
    logic        e_wb = 0, e_rw = 0, e_m2r = 0, e_mis = 0, e_bus = 0;
    logic [31:0] e_rd = '0, e_alu = '0;
    logic [4:0]  e_wr = '0;
    logic        m_stall = 0;
    int          lat_sel = -1;
    logic        use_fix = 0;
    logic [31:0] fix_val = '0;
    int          stall_cnt = 0, req_run = 0, last_req = 0, wb_cnt = 0, bus_cnt = 0;
    logic [31:0] last_rd = '0;

    task automatic tick();
        logic was_busy, exp_stall, memop;
        was_busy = m_busy;
        if (m_busy) i_dmem_ack = (m_age == p_lat);
        else        i_dmem_ack = ($urandom_range(0, 3) == 0);
        i_dmem_rdata = use_fix ? fix_val : $urandom;
        #1;
        exp_stall = 0;
        e_mis = 0;
        e_bus = 0;
        e_wb  = 0;
        if (!m_busy) begin
            memop = i_in_valid && (i_mem_read_in || i_mem_write_in);
            if (memop && !i_flush && i_alu_result[1:0] != 2'b00) begin
                e_wb = 1; e_rw = 0; e_m2r = i_mem_to_reg_in; e_rd = '0;
                e_alu = i_alu_result; e_wr = i_write_reg; e_mis = 1;
            end else if (memop && !i_flush) begin
                exp_stall = 1; m_busy = 1; m_age = 0;
                p_addr = i_alu_result; p_wdata = i_store_data; p_we = i_mem_write_in;
                p_rw = i_reg_write_in && !(i_mem_read_in && i_mem_write_in);
                p_m2r = i_mem_to_reg_in; p_wr = i_write_reg;
                p_lat = (lat_sel < 0) ? int'($urandom_range(0, 17)) : lat_sel;
            end else begin
                e_wb = i_in_valid && !i_flush; e_rw = i_reg_write_in; e_m2r = i_mem_to_reg_in;
                e_rd = '0; e_alu = i_alu_result; e_wr = i_write_reg;
            end
        end else begin
            exp_stall = !i_dmem_ack;
            if (i_dmem_ack) begin
                e_wb = 1; e_rw = p_rw; e_m2r = p_m2r; e_rd = p_we ? 32'h0 : i_dmem_rdata;
                e_alu = p_addr; e_wr = p_wr; m_busy = 0;
            end else if (m_age + 1 == TO) begin
                e_wb = 1; e_rw = 0; e_m2r = p_m2r; e_rd = '0;
                e_alu = p_addr; e_wr = p_wr; e_bus = 1; m_busy = 0;
            end else begin
                m_age++;
            end
        end
        chk("stall", o_stall, exp_stall);
        chk("dmem_req", o_dmem_req, was_busy);
        if (was_busy) begin
            chk("dmem_addr", o_dmem_addr, p_addr);
            chk("dmem_wdata", o_dmem_wdata, p_wdata);
            chk("dmem_we", o_dmem_we, p_we);
        end
        if (o_stall) stall_cnt++;
        if (o_dmem_req) req_run++;
        if (was_busy && !m_busy) begin
            last_req = req_run;
            req_run  = 0;
        end
        m_stall = exp_stall;
        @(posedge clk);
        #1;
        chk("wb_valid", o_wb_valid, e_wb);
        chk("misalign_err", o_misalign_err, e_mis);
        chk("bus_err", o_bus_err, e_bus);
        if (e_wb) begin
            chk("reg_write_out", o_reg_write_out, e_rw);
            chk("mem_to_reg_out", o_mem_to_reg_out, e_m2r);
            chk("read_data", o_read_data, e_rd);
            chk("alu_out", o_alu_out, e_alu);
            chk("write_reg_out", o_write_reg_out, e_wr);
        end
        if (o_wb_valid) begin
            wb_cnt++;
            last_rd = o_read_data;
        end
        if (o_bus_err) bus_cnt++;
        @(negedge clk);
    endtask

    task automatic drive(input logic v, rd, wr, m2r, rw, input logic [31:0] alu, sd,
                         input logic [4:0] wreg, input logic fl);
        i_in_valid = v; i_mem_read_in = rd; i_mem_write_in = wr; i_mem_to_reg_in = m2r;
        i_reg_write_in = rw; i_alu_result = alu; i_store_data = sd; i_write_reg = wreg;
        i_flush = fl;
    endtask

    task automatic run_access();
        tick();
        for (int n = 0; n < 40 && m_busy; n++) tick();
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0);
        tick();
    endtask

    task automatic clear_stats();
        stall_cnt = 0; req_run = 0; last_req = 0; wb_cnt = 0; bus_cnt = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"}, o_dmem_req, 0);
        chk({tag, "_stall"}, o_stall, 0);
        chk({tag, "_wb"}, o_wb_valid, 0);
        chk({tag, "_we"}, o_dmem_we, 0);
        chk({tag, "_addr"}, o_dmem_addr, 0);
        chk({tag, "_wdata"}, o_dmem_wdata, 0);
        chk({tag, "_rw"}, o_reg_write_out, 0);
        chk({tag, "_m2r"}, o_mem_to_reg_out, 0);
        chk({tag, "_rd"}, o_read_data, 0);
        chk({tag, "_alu"}, o_alu_out, 0);
        chk({tag, "_wr"}, o_write_reg_out, 0);
        chk({tag, "_mis"}, o_misalign_err, 0);
        chk({tag, "_bus"}, o_bus_err, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // ALU op passes straight through in one cycle.
        drive(1, 0, 0, 0, 1, 32'h0000_1234, 32'h0, 5'd5, 0);
        clear_stats();
        tick();
        chk("alu_wb", o_wb_valid, 1);
        chk("alu_out_1234", o_alu_out, 32'h0000_1234);
        chk("alu_wr5", o_write_reg_out, 5'd5);
        chk("alu_nostall", stall_cnt, 0);

        // Load, ack on the 4th WAIT cycle.
        clear_stats();
        lat_sel = 3; use_fix = 1; fix_val = 32'hDEAD_BEEF;
        drive(1, 1, 0, 1, 1, 32'h0000_0100, 32'h0, 5'd7, 0);
        run_access();
        chk("load_stall4", stall_cnt, 4);
        chk("load_wb1", wb_cnt, 1);
        chk("load_rdata", last_rd, 32'hDEAD_BEEF);
        use_fix = 0;

        // Misaligned store.
        clear_stats();
        drive(1, 0, 1, 0, 0, 32'h0000_0103, 32'h55AA_55AA, 5'd0, 0);
        tick();
        chk("mis_err", o_misalign_err, 1);
        chk("mis_noreq", req_run, 0);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0);
        tick();

        // Timeout, then ack on the last permitted cycle.
        clear_stats();
        lat_sel = 99;
        drive(1, 1, 0, 1, 1, 32'h0000_0200, 32'h0, 5'd9, 0);
        run_access();
        chk("to_req15", last_req, TO);
        chk("to_buserr", bus_cnt, 1);
        chk("to_wb1", wb_cnt, 1);
        clear_stats();
        lat_sel = TO - 1;
        drive(1, 1, 0, 1, 1, 32'h0000_0204, 32'h0, 5'd9, 0);
        run_access();
        chk("late_req15", last_req, TO);
        chk("late_nobus", bus_cnt, 0);

        // Flush in IDLE suppresses; flush during WAIT is ignored.
        clear_stats();
        drive(1, 1, 0, 1, 1, 32'h0000_0300, 32'h0, 5'd3, 1);
        tick();
        chk("flush_noreq", req_run + last_req, 0);
        chk("flush_nowb", wb_cnt, 0);
        clear_stats();
        lat_sel = 4;
        drive(1, 1, 0, 1, 1, 32'h0000_0304, 32'h0, 5'd3, 0);
        tick();
        i_flush = 1;
        for (int n = 0; n < 40 && m_busy; n++) tick();
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0);
        tick();
        chk("wflush_wb1", wb_cnt, 1);

        // Read+write together acts as a store with no register write.
        lat_sel = 1;
        drive(1, 1, 1, 0, 1, 32'h0000_0408, 32'hCAFE_F00D, 5'd4, 0);
        run_access();

        // Reset in the middle of WAIT.
        lat_sel = 99;
        drive(1, 1, 0, 1, 1, 32'h0000_0500, 32'h0, 5'd2, 0);
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", o_dmem_req, 0);
        chk("arst_stall", o_stall, 0);
        chk("arst_wb", o_wb_valid, 0);
        m_busy = 0; e_wb = 0; e_mis = 0; e_bus = 0;
        @(negedge clk);
        check_all_zero("arst");
        rst_n = 1'b1;
        clear_stats();
        lat_sel = 2;
        drive(1, 1, 0, 1, 1, 32'h0000_0600, 32'h0, 5'd6, 0);
        run_access();
        chk("post_rst_wb1", wb_cnt, 1);
        chk("post_rst_req", last_req, 3);

        // Randomized traffic; the upstream holds its instruction while stalled.
        lat_sel = -1;
        for (int i = 0; i < 3000; i++) begin
            if (!m_stall) begin
                int kind;
                kind = $urandom_range(0, 3);
                i_in_valid      = ($urandom_range(0, 4) != 0);
                i_mem_read_in   = (kind == 1) || (kind == 3);
                i_mem_write_in  = (kind == 2) || (kind == 3);
                i_mem_to_reg_in = $urandom_range(0, 1);
                i_reg_write_in  = $urandom_range(0, 1);
                i_alu_result    = $urandom;
                if ($urandom_range(0, 3) != 0) i_alu_result[1:0] = 2'b00;
                i_store_data    = $urandom;
                i_write_reg     = 5'($urandom_range(0, 31));
            end
            i_flush = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
